// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Purpose  : Behavioural SDRAM target. Decodes {CS,RAS,CAS,WE} on every
//            rising edge, tracks per-bank open rows, serves READs after
//            CAS_LAT edges and commits WRITE data WR_LAT edges after the
//            command. Protocol violations are flagged and counted.
// Ports    : in_HCLK / in_HRESETn       clock, async active-low reset
//            in_CS/in_RAS/in_CAS/in_write_en  command strobes (active low)
//            in_bank_select, in_sdram_addr, in_sdram_write_data
//            out_sdram_read_data, out_read_valid   read return
//            out_cmd_error, out_err_count          protocol error pulse/count
//            out_row_miss                          open row replaced by ACT
// Revision : 1.0 - initial release
// ============================================================================
module sdram_responder #(
    parameter int CAS_LAT = 1,
    parameter int WR_LAT  = 2,
    parameter int ROW_W   = 4,
    parameter int COL_W   = 4
) (
    input  logic        in_HCLK,
    input  logic        in_HRESETn,
    input  logic        in_CS,
    input  logic        in_RAS,
    input  logic        in_CAS,
    input  logic        in_write_en,
    input  logic [1:0]  in_bank_select,
    input  logic [13:0] in_sdram_addr,
    input  logic [31:0] in_sdram_write_data,
    output logic [31:0] out_sdram_read_data,
    output logic        out_read_valid,
    output logic        out_cmd_error,
    output logic        out_row_miss,
    output logic [7:0]  out_err_count
);
    localparam int c_AW    = 2 + ROW_W + COL_W;
    localparam int c_DEPTH = 1 << c_AW;

    typedef enum logic [0:0] {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    logic [3:0]       w_cmd;
    logic [1:0]       w_bank;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic [c_AW-1:0]  w_addr;
    logic             w_access_ok;
    logic             w_rd_go;
    logic             w_wr_go;
    logic             w_err;
    logic             w_row_miss;
    logic             w_unused_addr;

    bank_state_t      r_state        [4];
    bank_state_t      w_state_nxt    [4];
    logic [ROW_W-1:0] r_open_row     [4];
    logic [ROW_W-1:0] w_open_row_nxt [4];
    logic [3:0]       r_act_last;
    logic [3:0]       w_act_nxt;

    logic [31:0]      r_mem     [c_DEPTH];
    logic             r_rd_vld  [CAS_LAT];
    logic [31:0]      r_rd_data [CAS_LAT];
    logic             r_wr_vld  [WR_LAT];
    logic [c_AW-1:0]  r_wr_addr [WR_LAT];
    logic             r_err_pend;

    assign w_cmd  = {in_CS, in_RAS, in_CAS, in_write_en};
    assign w_bank = in_bank_select;
    assign w_row  = in_sdram_addr[ROW_W-1:0];
    assign w_col  = in_sdram_addr[COL_W-1:0];
    assign w_addr = {w_bank, r_open_row[w_bank], w_col};

    // Address bits beyond the row/column fields (other than A10) carry no meaning.
    assign w_unused_addr = ^in_sdram_addr;

    // A column access needs an open bank whose ACT was not sampled on the
    // immediately preceding edge.
    assign w_access_ok = (r_state[w_bank] == BANK_ACTIVE) && !r_act_last[w_bank];

    // Command decode and next bank state
    always_comb begin
        w_state_nxt    = r_state;
        w_open_row_nxt = r_open_row;
        w_act_nxt      = 4'b0000;
        w_rd_go        = 1'b0;
        w_wr_go        = 1'b0;
        w_err          = 1'b0;
        w_row_miss     = 1'b0;
        casez (w_cmd)
            4'b1???, 4'b0111: begin
            end
            4'b0011: begin
                // ACT on an open bank is a silent close-and-reopen.
                w_row_miss             = (r_state[w_bank] == BANK_ACTIVE) &&
                                         (r_open_row[w_bank] != w_row);
                w_state_nxt[w_bank]    = BANK_ACTIVE;
                w_open_row_nxt[w_bank] = w_row;
                w_act_nxt[w_bank]      = 1'b1;
            end
            4'b0101: begin
                if (w_access_ok) w_rd_go = 1'b1;
                else             w_err   = 1'b1;
            end
            4'b0100: begin
                if (w_access_ok) w_wr_go = 1'b1;
                else             w_err   = 1'b1;
            end
            4'b0010: begin
                if (in_sdram_addr[10]) begin
                    for (int b = 0; b < 4; b++) w_state_nxt[b] = BANK_IDLE;
                end else begin
                    w_state_nxt[w_bank] = BANK_IDLE;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    // Bank state, read/write pipelines and status outputs
    always_ff @(posedge in_HCLK or negedge in_HRESETn) begin
        if (!in_HRESETn) begin
            for (int b = 0; b < 4; b++) begin
                r_state[b]    <= BANK_IDLE;
                r_open_row[b] <= '0;
            end
            r_act_last <= 4'b0000;
            for (int i = 0; i < CAS_LAT; i++) begin
                r_rd_vld[i]  <= 1'b0;
                r_rd_data[i] <= 32'h0;
            end
            for (int i = 0; i < WR_LAT; i++) begin
                r_wr_vld[i]  <= 1'b0;
                r_wr_addr[i] <= '0;
            end
            r_err_pend          <= 1'b0;
            out_sdram_read_data <= 32'h0;
            out_read_valid      <= 1'b0;
            out_cmd_error       <= 1'b0;
            out_row_miss        <= 1'b0;
            out_err_count       <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_open_row <= w_open_row_nxt;
            r_act_last <= w_act_nxt;

            // The word is fetched at the command edge, so a write committing
            // on this same edge is not yet visible (read-before-write).
            r_rd_vld[0]  <= w_rd_go;
            r_rd_data[0] <= r_mem[w_addr];
            for (int i = 1; i < CAS_LAT; i++) begin
                r_rd_vld[i]  <= r_rd_vld[i-1];
                r_rd_data[i] <= r_rd_data[i-1];
            end
            out_read_valid <= r_rd_vld[CAS_LAT-1];
            if (r_rd_vld[CAS_LAT-1]) begin
                out_sdram_read_data <= r_rd_data[CAS_LAT-1];
            end

            r_wr_vld[0]  <= w_wr_go;
            r_wr_addr[0] <= w_addr;
            for (int i = 1; i < WR_LAT; i++) begin
                r_wr_vld[i]  <= r_wr_vld[i-1];
                r_wr_addr[i] <= r_wr_addr[i-1];
            end

            out_row_miss  <= w_row_miss;
            r_err_pend    <= w_err;
            out_cmd_error <= r_err_pend;
            if (r_err_pend && (out_err_count != 8'hFF)) begin
                out_err_count <= out_err_count + 8'd1;
            end
        end
    end

    // Storage is not reset; data is taken from the bus on the commit edge.
    always_ff @(posedge in_HCLK) begin
        if (r_wr_vld[WR_LAT-1]) begin
            r_mem[r_wr_addr[WR_LAT-1]] <= in_sdram_write_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_responder
// Purpose  : Directed, scoreboard-checked bench for sdram_responder. Stimulus
//            tasks push expected read data, error pulses and row-miss pulses
//            into queues tagged with the cycle they must appear on; a monitor
//            on the falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;
    localparam int CAS_LAT = 1;
    localparam int WR_LAT  = 2;
    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;

    localparam logic [3:0] c_NOP = 4'b0111;
    localparam logic [3:0] c_ACT = 4'b0011;
    localparam logic [3:0] c_RD  = 4'b0101;
    localparam logic [3:0] c_WR  = 4'b0100;
    localparam logic [3:0] c_PRE = 4'b0010;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [1:0]  bank = 2'd0;
    logic [13:0] addr = 14'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        rvalid, cmd_err, row_miss;
    logic [7:0]  err_cnt;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;
    int          err_model = 0;
    logic [31:0] last_rd = 32'h0;
    exp_t        rd_q[$];
    exp_t        err_q[$];
    int          rm_q[$];

    sdram_responder #(
        .CAS_LAT(CAS_LAT), .WR_LAT(WR_LAT), .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .in_HCLK             (clk),
        .in_HRESETn          (rst_n),
        .in_CS               (cs),
        .in_RAS              (ras),
        .in_CAS              (cas),
        .in_write_en         (we),
        .in_bank_select      (bank),
        .in_sdram_addr       (addr),
        .in_sdram_write_data (wdata),
        .out_sdram_read_data (rdata),
        .out_read_valid      (rvalid),
        .out_cmd_error       (cmd_err),
        .out_row_miss        (row_miss),
        .out_err_count       (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // One command slot: drive at the falling edge, returns the sample edge number.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [13:0] a,
                         input logic [31:0] d, output int s);
        @(negedge clk);
        {cs, ras, cas, we} = c;
        bank  = b;
        addr  = a;
        wdata = d;
        s     = cyc + 1;
    endtask

    task automatic nop(input logic [31:0] d);
        int s;
        issue(c_NOP, 2'd0, 14'd0, d, s);
    endtask

    task automatic act(input logic [1:0] b, input logic [13:0] a, input bit miss);
        int s;
        issue(c_ACT, b, a, 32'd0, s);
        if (miss) rm_q.push_back(s);
    endtask

    task automatic pre(input logic [1:0] b, input logic [13:0] a);
        int s;
        issue(c_PRE, b, a, 32'd0, s);
    endtask

    task automatic rd(input logic [1:0] b, input logic [13:0] a,
                      input logic [31:0] exp, input logic [31:0] d);
        int   s;
        exp_t e;
        issue(c_RD, b, a, d, s);
        e.cyc = s + CAS_LAT;
        e.val = exp;
        rd_q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] b, input logic [13:0] a);
        int s;
        issue(c_WR, b, a, 32'd0, s);
    endtask

    task automatic wr_full(input logic [1:0] b, input logic [13:0] a, input logic [31:0] d);
        wr(b, a);
        repeat (WR_LAT - 1) nop(32'd0);
        nop(d);
    endtask

    task automatic bad(input logic [3:0] c, input logic [1:0] b, input logic [13:0] a);
        int   s;
        exp_t e;
        issue(c, b, a, 32'd0, s);
        if (err_model < 255) err_model++;
        e.cyc = s + 1;
        e.val = 32'(err_model);
        err_q.push_back(e);
    endtask

    task automatic chk_reset_outputs();
        check("reset_read_data",  rdata,           32'h0);
        check("reset_read_valid", {31'd0, rvalid},   32'h0);
        check("reset_cmd_error",  {31'd0, cmd_err},  32'h0);
        check("reset_row_miss",   {31'd0, row_miss}, 32'h0);
        check("reset_err_count",  {24'd0, err_cnt},  32'h0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (!rst_n) last_rd = 32'h0;

        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            e = rd_q.pop_front();
            check("read_valid", {31'd0, rvalid}, 32'd1);
            check("read_data", rdata, e.val);
            last_rd = e.val;
        end else begin
            check("read_valid_idle", {31'd0, rvalid}, 32'd0);
            check("read_data_hold", rdata, last_rd);
        end

        if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
            e = err_q.pop_front();
            check("cmd_error", {31'd0, cmd_err}, 32'd1);
            check("err_count", {24'd0, err_cnt}, e.val);
        end else begin
            check("cmd_error_idle", {31'd0, cmd_err}, 32'd0);
        end

        if (rm_q.size() > 0 && rm_q[0] == cyc) begin
            void'(rm_q.pop_front());
            check("row_miss", {31'd0, row_miss}, 32'd1);
        end else begin
            check("row_miss_idle", {31'd0, row_miss}, 32'd0);
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // Column access to an idle bank straight out of reset
        bad(c_RD, 2'd2, 14'd0);

        // Write then read back through a re-opened row
        act(2'd1, 14'd3, 1'b0);
        nop(32'd0);
        wr_full(2'd1, 14'd5, 32'hCAFE_F00D);
        pre(2'd1, 14'd0);
        act(2'd1, 14'd3, 1'b0);
        nop(32'd0);
        rd(2'd1, 14'd5, 32'hCAFE_F00D, 32'd0);

        // Back-to-back writes then back-to-back reads (WR_LAT = 2 slot layout)
        act(2'd3, 14'd7, 1'b0);
        nop(32'd0);
        wr(2'd3, 14'd1);
        wr(2'd3, 14'd2);
        nop(32'h0A0A_1111);
        nop(32'h0B0B_2222);
        rd(2'd3, 14'd1, 32'h0A0A_1111, 32'd0);
        rd(2'd3, 14'd2, 32'h0B0B_2222, 32'd0);

        // Read sampled on the commit edge of a write to the same word sees old data
        wr(2'd3, 14'd1);
        nop(32'd0);
        rd(2'd3, 14'd1, 32'h0A0A_1111, 32'h0C0C_3333);
        nop(32'd0);
        rd(2'd3, 14'd1, 32'h0C0C_3333, 32'd0);
        rd(2'd3, 14'h2A01, 32'h0C0C_3333, 32'd0);   // upper column bits ignored

        // tRCD violation
        act(2'd0, 14'd1, 1'b0);
        bad(c_RD, 2'd0, 14'd0);

        // Row replacement
        nop(32'd0);
        act(2'd0, 14'd2, 1'b1);
        nop(32'd0);
        act(2'd0, 14'h0012, 1'b0);                  // same row, upper bits ignored

        // Illegal encodings and an inhibited slot
        bad(4'b0110, 2'd0, 14'd0);
        bad(4'b0001, 2'd0, 14'd0);
        bad(4'b0000, 2'd0, 14'd0);
        begin : inh
            int s;
            issue(4'b1000, 2'd0, 14'd0, 32'd0, s);
        end
        nop(32'd0);

        // Precharge-all closes banks 0 and 3
        pre(2'd1, 14'h0400);
        bad(c_WR, 2'd3, 14'd1);
        bad(c_WR, 2'd0, 14'd1);

        // Reset in the middle of a write
        act(2'd2, 14'd5, 1'b0);
        nop(32'd0);
        wr_full(2'd2, 14'd9, 32'h1111_2222);
        wr(2'd2, 14'd9);
        nop(32'd0);
        @(negedge clk);
        {cs, ras, cas, we} = c_NOP;
        wdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        err_model = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        wdata = 32'd0;
        #2 rst_n = 1'b1;
        act(2'd2, 14'd5, 1'b0);
        nop(32'd0);
        rd(2'd2, 14'd9, 32'h1111_2222, 32'd0);
        bad(c_RD, 2'd0, 14'd0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) bad(4'b0110, 2'd0, 14'd0);

        repeat (6) nop(32'd0);
        check("read_queue_drained",  32'(rd_q.size()),  32'd0);
        check("error_queue_drained", 32'(err_q.size()), 32'd0);
        check("miss_queue_drained",  32'(rm_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
